// File: rtl/gip_boot_rom_arbiter_pkg.sv
// Shared types and defaults for the GIP boot ROM arbiter.
//   t_rom_port : which requester owns a ROM slot (NONE, FETCH or DATA)
//   ADDR_W_DEFAULT / DATA_W_DEFAULT : default ROM word-address and data widths
package gip_boot_rom_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } t_rom_port;

endpackage

// File: rtl/gip_boot_rom_arbiter_if.sv
// Requester-side bus of the boot ROM arbiter: the instruction-fetch port and
// the data/debug read port.
//   *_req / *_address : request held with its address until *_ack
//   *_ack             : request accepted this cycle
//   *_valid / *_data  : read return, two cycles after the ack
// Modports: master = requester side, slave = arbiter side.
interface gip_boot_rom_arbiter_if
  import gip_boot_rom_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_address;
  logic              fetch_ack;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;

  logic              data_req;
  logic [ADDR_W-1:0] data_address;
  logic              data_ack;
  logic              data_valid;
  logic [DATA_W-1:0] data_data;

  modport master (
    output fetch_req, fetch_address, data_req, data_address,
    input  fetch_ack, fetch_valid, fetch_data, data_ack, data_valid, data_data
  );

  modport slave (
    input  fetch_req, fetch_address, data_req, data_address,
    output fetch_ack, fetch_valid, fetch_data, data_ack, data_valid, data_data
  );

endinterface

// File: rtl/gip_boot_rom_arbiter.sv
// Two-port read arbiter in front of the single-ported synchronous boot ROM.
// At most one ROM access is issued per cycle; read data returns exactly two
// cycles after the ack (ack in N, ROM enable/address in N+1, data in N+2).
// Ports:
//   rom_clock     : single clock, rising edge
//   rom_reset     : asynchronous active-low reset
//   bus           : fetch and data request/return ports (slave modport)
//   rom_address   : registered ROM word address
//   rom_read      : registered ROM read enable
//   rom_read_data : ROM output, valid the cycle after rom_read is sampled
// Parameters:
//   FETCH_PRIORITY 1: fetch wins ties unless it has already won MAX_FETCH_RUN
//                  times in a row against a waiting data request; 0: round-robin.
//   MAX_FETCH_RUN  must be at least 1.
// Optional feature: define GIP_BOOT_ROM_FETCH_BUFFER_EN to add a one-entry
// fetch buffer that answers repeated fetch addresses without a ROM access.
module gip_boot_rom_arbiter
  import gip_boot_rom_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int FETCH_PRIORITY = 1,
  parameter int MAX_FETCH_RUN  = 4
) (
  input  logic                  rom_clock,
  input  logic                  rom_reset,
  gip_boot_rom_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]     rom_address,
  output logic                  rom_read,
  input  logic [DATA_W-1:0]     rom_read_data
);

  localparam int              RUN_W   = $clog2(MAX_FETCH_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_FETCH_RUN);

  t_rom_port        grant_s;
  t_rom_port        last_grant_r;
  t_rom_port        tag1_r;
  t_rom_port        tag2_r;
  logic [RUN_W-1:0] fetch_run_r;
  logic             hit_s;
  logic             fetch_arb_s;

  // Choose the single ROM user for this cycle; a buffer hit never competes.
  always_comb begin
    grant_s     = NONE;
    fetch_arb_s = bus.fetch_req && !hit_s;
    if (!rom_reset) begin
      grant_s = NONE;
    end else if (fetch_arb_s && bus.data_req) begin
      if (FETCH_PRIORITY != 0) begin
        // fetch_run saturates, so equality is the starvation limit
        if (fetch_run_r == RUN_MAX) grant_s = DATA;
        else                        grant_s = FETCH;
      end else begin
        if (last_grant_r == FETCH) grant_s = DATA;
        else                       grant_s = FETCH;
      end
    end else if (fetch_arb_s) begin
      grant_s = FETCH;
    end else if (bus.data_req) begin
      grant_s = DATA;
    end else begin
      grant_s = NONE;
    end
  end

  assign bus.fetch_ack = (grant_s == FETCH) || hit_s;
  assign bus.data_ack  = (grant_s == DATA);

  // Issue the ROM access and carry the owner tag down the two-stage pipe.
  always_ff @(posedge rom_clock or negedge rom_reset) begin
    if (!rom_reset) begin
      rom_read     <= 1'b0;
      rom_address  <= {ADDR_W{1'b0}};
      tag1_r       <= NONE;
      tag2_r       <= NONE;
      last_grant_r <= DATA;
      fetch_run_r  <= {RUN_W{1'b0}};
    end else begin
      rom_read <= (grant_s != NONE);
      if (grant_s == FETCH)     rom_address <= bus.fetch_address;
      else if (grant_s == DATA) rom_address <= bus.data_address;
      tag1_r <= grant_s;
      tag2_r <= tag1_r;
      if (grant_s != NONE) last_grant_r <= grant_s;
      if (!bus.data_req || (grant_s == DATA)) begin
        fetch_run_r <= {RUN_W{1'b0}};
      end else if ((grant_s == FETCH) && (fetch_run_r != RUN_MAX)) begin
        fetch_run_r <= fetch_run_r + RUN_W'(1);
      end
    end
  end

  assign bus.data_valid = (tag2_r == DATA);
  assign bus.data_data  = rom_read_data;

`ifdef GIP_BOOT_ROM_FETCH_BUFFER_EN
  logic              buf_valid_r;
  logic [ADDR_W-1:0] buf_addr_r;
  logic [DATA_W-1:0] buf_data_r;
  logic [ADDR_W-1:0] fill_addr_r;
  logic              hit1_r;
  logic              hit2_r;
  logic [DATA_W-1:0] hit_data1_r;
  logic [DATA_W-1:0] hit_data2_r;

  assign hit_s = rom_reset && bus.fetch_req && buf_valid_r &&
                 (bus.fetch_address == buf_addr_r);

  // Refill the buffer from every fetch ROM read; hit data is copied into its
  // own pipe at hit time so a later refill cannot change what is returned.
  always_ff @(posedge rom_clock or negedge rom_reset) begin
    if (!rom_reset) begin
      buf_valid_r <= 1'b0;
      buf_addr_r  <= {ADDR_W{1'b0}};
      buf_data_r  <= {DATA_W{1'b0}};
      fill_addr_r <= {ADDR_W{1'b0}};
      hit1_r      <= 1'b0;
      hit2_r      <= 1'b0;
      hit_data1_r <= {DATA_W{1'b0}};
      hit_data2_r <= {DATA_W{1'b0}};
    end else begin
      if (tag1_r == FETCH) fill_addr_r <= rom_address;
      if (tag2_r == FETCH) begin
        buf_valid_r <= 1'b1;
        buf_addr_r  <= fill_addr_r;
        buf_data_r  <= rom_read_data;
      end
      hit1_r      <= hit_s;
      hit2_r      <= hit1_r;
      hit_data1_r <= buf_data_r;
      hit_data2_r <= hit_data1_r;
    end
  end

  // A hit and a fetch ROM grant never share a cycle, so these never overlap.
  assign bus.fetch_valid = (tag2_r == FETCH) || hit2_r;
  assign bus.fetch_data  = hit2_r ? hit_data2_r : rom_read_data;
`else
  assign hit_s           = 1'b0;
  assign bus.fetch_valid = (tag2_r == FETCH);
  assign bus.fetch_data  = rom_read_data;
`endif

endmodule

// File: tb/tb_gip_boot_rom_arbiter.sv
// Bench for gip_boot_rom_arbiter: a fetch-priority instance (lane 0) and a
// round-robin instance (lane 1) share stimulus. A cycle-level model checks
// both every cycle; directed checks pin literal expectations.
module tb_gip_boot_rom_arbiter;
  import gip_boot_rom_pkg::*;

  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int MAXRUN = 4;
`ifdef GIP_BOOT_ROM_FETCH_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rom_addr0, rom_addr1;
  logic          rom_rd0, rom_rd1;
  logic [DW-1:0] rom_q0, rom_q1;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  gip_boot_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  gip_boot_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  gip_boot_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FETCH_PRIORITY(1), .MAX_FETCH_RUN(MAXRUN)) dut_pri (
    .rom_clock(clk), .rom_reset(rst_n), .bus(bus0),
    .rom_address(rom_addr0), .rom_read(rom_rd0), .rom_read_data(rom_q0));

  gip_boot_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FETCH_PRIORITY(0), .MAX_FETCH_RUN(MAXRUN)) dut_rr (
    .rom_clock(clk), .rom_reset(rst_n), .bus(bus1),
    .rom_address(rom_addr1), .rom_read(rom_rd1), .rom_read_data(rom_q1));

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {20'hB0070, a};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous ROMs: data registered on the edge that samples rom_read
  always @(posedge clk) begin
    if (rom_rd0) rom_q0 <= rom_word(rom_addr0);
    if (rom_rd1) rom_q1 <= rom_word(rom_addr1);
  end

  task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", name, lane, cyc, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [AW-1:0] fa, input logic d, input logic [AW-1:0] da);
    bus0.fetch_req = f; bus0.fetch_address = fa; bus0.data_req = d; bus0.data_address = da;
    bus1.fetch_req = f; bus1.fetch_address = fa; bus1.data_req = d; bus1.data_address = da;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- model state (per lane) ----------------
  int            m_last [2];          // 0 = fetch granted last, 1 = data
  int            m_run  [2];
  bit            fs_v [2][4];         // fetch return due in slot (cycle % 4)
  bit            fs_h [2][4];         // that return is a buffer hit
  logic [AW-1:0] fs_a [2][4];
  bit            ds_v [2][4];
  logic [AW-1:0] ds_a [2][4];
  bit            m_rd [2];
  logic [AW-1:0] m_ra [2];
  bit            b_v  [2];
  logic [AW-1:0] b_a  [2];

  always @(negedge clk) begin
    logic f_req, d_req, f_ack, d_ack, f_v, d_v, r_rd, hit, gf, gd, e_fv, e_dv;
    logic [AW-1:0] f_a, d_a, r_a;
    logic [DW-1:0] f_d, d_d;
    int s, s2;
    for (int l = 0; l < 2; l++) begin
      if (l == 0) begin
        f_req = bus0.fetch_req; f_a = bus0.fetch_address; d_req = bus0.data_req; d_a = bus0.data_address;
        f_ack = bus0.fetch_ack; d_ack = bus0.data_ack; f_v = bus0.fetch_valid; d_v = bus0.data_valid;
        f_d = bus0.fetch_data; d_d = bus0.data_data; r_rd = rom_rd0; r_a = rom_addr0;
      end else begin
        f_req = bus1.fetch_req; f_a = bus1.fetch_address; d_req = bus1.data_req; d_a = bus1.data_address;
        f_ack = bus1.fetch_ack; d_ack = bus1.data_ack; f_v = bus1.fetch_valid; d_v = bus1.data_valid;
        f_d = bus1.fetch_data; d_d = bus1.data_data; r_rd = rom_rd1; r_a = rom_addr1;
      end
      if (!rst_n) begin
        chk("acks_in_reset", l, {f_ack, d_ack}, 2'b00);
        chk("valids_in_reset", l, {f_v, d_v}, 2'b00);
        chk("rom_read_in_reset", l, r_rd, 1'b0);
        chk("rom_address_in_reset", l, r_a, 12'h000);
        m_last[l] = 1; m_run[l] = 0; m_rd[l] = 1'b0; m_ra[l] = '0; b_v[l] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          fs_v[l][k] = 1'b0; ds_v[l][k] = 1'b0;
        end
      end else begin
        s  = cyc % 4;
        s2 = (cyc + 2) % 4;
        e_fv = fs_v[l][s];
        e_dv = ds_v[l][s];
        chk("fetch_valid", l, f_v, e_fv);
        chk("data_valid", l, d_v, e_dv);
        if (e_fv && f_v) chk("fetch_data", l, f_d, rom_word(fs_a[l][s]));
        if (e_dv && d_v) chk("data_data", l, d_d, rom_word(ds_a[l][s]));
        chk("rom_read", l, r_rd, m_rd[l]);
        chk("rom_address", l, r_a, m_ra[l]);
        hit = BUF_EN && f_req && b_v[l] && (b_a[l] == f_a);
        gf = 1'b0; gd = 1'b0;
        if (f_req && !hit && d_req) begin
          if (l == 0) gf = (m_run[l] < MAXRUN);
          else        gf = (m_last[l] == 1);
          gd = !gf;
        end else begin
          gf = f_req && !hit;
          gd = d_req;
        end
        chk("fetch_ack", l, f_ack, gf || hit);
        chk("data_ack", l, d_ack, gd);
        // end-of-cycle effects
        if (e_fv && !fs_h[l][s]) begin
          b_v[l] = 1'b1; b_a[l] = fs_a[l][s];
        end
        fs_v[l][s] = 1'b0; ds_v[l][s] = 1'b0;
        if (gf || hit) begin
          fs_v[l][s2] = 1'b1; fs_h[l][s2] = hit; fs_a[l][s2] = f_a;
        end
        if (gd) begin
          ds_v[l][s2] = 1'b1; ds_a[l][s2] = d_a;
        end
        m_rd[l] = gf || gd;
        if (gf)      m_ra[l] = f_a;
        else if (gd) m_ra[l] = d_a;
        if (gf)      m_last[l] = 0;
        else if (gd) m_last[l] = 1;
        if (!d_req || gd)               m_run[l] = 0;
        else if (gf && m_run[l] < MAXRUN) m_run[l] = m_run[l] + 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    string seq0, seq1;
    int    rd_count;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    repeat (3) step();
    rst_n = 1'b1;

    // 1: single fetch of 0x010
    drive(1'b1, 12'h010, 1'b0, 12'h000);
    #2 chk("t1_fetch_ack", 0, bus0.fetch_ack, 1'b1);
    step();
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    #2 chk("t1_rom_read", 0, rom_rd0, 1'b1);
    chk("t1_rom_address", 0, rom_addr0, 12'h010);
    step();
    #2 chk("t1_fetch_valid", 0, bus0.fetch_valid, 1'b1);
    chk("t1_fetch_data", 0, bus0.fetch_data, 32'hB007_0010);
    chk("t1_no_data_valid", 0, bus0.data_valid, 1'b0);
    step();

    // 2/3: both requests held from reset
    do_reset();
    drive(1'b1, 12'h100, 1'b1, 12'h200);
    seq0 = ""; seq1 = "";
    for (int i = 0; i < 10; i++) begin
      #2;
      seq0 = {seq0, bus0.fetch_ack ? "F" : (bus0.data_ack ? "D" : "-")};
      seq1 = {seq1, bus1.fetch_ack ? "F" : (bus1.data_ack ? "D" : "-")};
      step();
    end
    drive(1'b0, 12'h000, 1'b0, 12'h000);
`ifndef GIP_BOOT_ROM_FETCH_BUFFER_EN
    chk_str("t2_priority_grants", seq0, "FFFFDFFFFD");
    chk_str("t3_round_robin_grants", seq1, "FDFDFDFDFD");
`endif
    repeat (3) step();

    // 4: reset asserted the cycle after an ack
    drive(1'b1, 12'h0AB, 1'b0, 12'h000);
    step();
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    rst_n = 1'b0;
    #2 chk("t4_rom_read_cleared", 0, rom_rd0, 1'b0);
    step();
    #2 chk("t4_no_stale_valid", 0, bus0.fetch_valid, 1'b0);
    chk("t4_no_stale_valid", 1, bus1.fetch_valid, 1'b0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 12'h0AC, 1'b0, 12'h000);
    step();
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    step();
    #2 chk("t4_restart_valid", 0, bus0.fetch_valid, 1'b1);
    chk("t4_restart_data", 0, bus0.fetch_data, 32'hB007_00AC);
    step();

    // 5: repeated fetch of 0x020 with a data request alongside the repeat
    do_reset();
    drive(1'b1, 12'h020, 1'b0, 12'h000);
    step();
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    repeat (3) step();
    rd_count = 0;
    drive(1'b1, 12'h020, 1'b1, 12'h030);
`ifdef GIP_BOOT_ROM_FETCH_BUFFER_EN
    #2 chk("t5_both_acks", 0, {bus0.fetch_ack, bus0.data_ack}, 2'b11);
    step();
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    #2 chk("t5_rom_address_data", 0, rom_addr0, 12'h030);
    rd_count += int'(rom_rd0);
    step();
    #2 chk("t5_valids", 0, {bus0.fetch_valid, bus0.data_valid}, 2'b11);
    chk("t5_fetch_data", 0, bus0.fetch_data, 32'hB007_0020);
    chk("t5_data_data", 0, bus0.data_data, 32'hB007_0030);
    chk("t5_rom_reads", 0, rd_count, 1);
`else
    #2 chk("t5_acks", 0, {bus0.fetch_ack, bus0.data_ack}, 2'b10);
    step();
    drive(1'b0, 12'h000, 1'b1, 12'h030);
    #2 chk("t5_rom_address_fetch", 0, rom_addr0, 12'h020);
    rd_count += int'(rom_rd0);
    step();
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    #2 chk("t5_fetch_data", 0, bus0.fetch_data, 32'hB007_0020);
    rd_count += int'(rom_rd0);
    step();
    #2 chk("t5_data_data", 0, bus0.data_data, 32'hB007_0030);
    chk("t5_rom_reads", 0, rd_count, 2);
`endif
    step();

    // 6: random soak over a small address range so buffer hits recur
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)));
      step();
    end
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
